im_loader: RTL and testbench

Byte-stream program loader that fills the instruction memory before the single-cycle core runs. It accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words to the instruction-memory write port and checks an XOR checksum. The core is held in reset until a load completes successfully. It sits between the host byte source and the instruction-memory write port, alongside the core.

---
 rtl/im_loader.sv | 218 +++++++++++++++++++++
 tb/tb_im_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// -----------------------------------------------------------------------------
// im_loader
//
// Loads a program into instruction memory from a framed byte stream before the
// single-cycle core is released. The frame layout is
//   LEN_LO, LEN_HI, 4*LEN data bytes (each word least-significant byte first),
//   CSUM (XOR of every data byte).
// Assembled words go out on a registered one-cycle write strobe. The core is
// held in reset until a frame is accepted with a matching checksum.
//
// Handshake: a byte is consumed on a rising clock edge exactly when
// in_valid && in_ready. in_ready is a pure function of the current state:
// high in LEN0, LEN1, DATA and CSUM, low in IDLE, DONE and ERR. It never drops
// inside DATA, so one byte per cycle is sustained.
//
// Ports
//   clk        : clock, all state changes on posedge
//   rst        : synchronous active-high reset
//   start      : one-cycle pulse, starts a load from IDLE, DONE or ERR
//   in_valid   : in_byte carries a stream byte
//   in_byte    : stream byte
//   in_ready   : loader accepts a byte this cycle
//   im_we      : instruction-memory write strobe (one cycle per word)
//   im_addr    : byte address of the write, word aligned
//   im_wdata   : assembled 32-bit word
//   core_hold  : holds the core in reset while high
//   done       : last load succeeded
//   error      : last load failed (length overflow or checksum mismatch)
//   dbg_state  : current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module im_loader #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        error,
  output logic [2:0]  dbg_state
);

  // word_idx must be able to count up to DEPTH itself.
  localparam int unsigned WIDX_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  // Only lanes 0..2 are stored; lane 3 is taken straight from in_byte when
  // the word is completed.
  logic [23:0]         word_q, word_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
  logic [7:0]          csum_q, csum_d;
  logic                im_we_q, im_we_d;
  logic [31:0]         im_addr_q, im_addr_d;
  logic [31:0]         im_wdata_q, im_wdata_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                core_hold_q, core_hold_d;

  logic                accept;
  logic [15:0]         len_full;
  logic [31:0]         word_off;
  logic                last_word;

  assign in_ready  = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                     (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign accept    = in_valid && in_ready;
  assign len_full  = {in_byte, len_q[7:0]};
  assign word_off  = 32'(word_idx_q) << 2;
  // True while the word currently being assembled is word len-1.
  assign last_word = (32'(word_idx_q) + 32'd1) == 32'(len_q);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_d      = word_q;
    byte_idx_d  = byte_idx_q;
    word_idx_d  = word_idx_q;
    csum_d      = csum_q;
    im_we_d     = 1'b0;
    im_addr_d   = im_addr_q;
    im_wdata_d  = im_wdata_q;
    done_d      = done_q;
    error_d     = error_q;
    core_hold_d = core_hold_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d     = ST_LEN0;
          done_d      = 1'b0;
          error_d     = 1'b0;
          core_hold_d = 1'b1;
          csum_d      = 8'h00;
          word_idx_d  = '0;
          byte_idx_d  = 2'd0;
          word_d      = 24'h0;
        end
      end

      ST_LEN0: begin
        if (accept) begin
          len_d[7:0] = in_byte;
          state_d    = ST_LEN1;
        end
      end

      ST_LEN1: begin
        if (accept) begin
          len_d[15:8] = in_byte;
          if (32'(len_full) > DEPTH) begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end else if (len_full == 16'h0000) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (accept) begin
          csum_d     = csum_q ^ in_byte;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: word_d[7:0]   = in_byte;
            2'd1: word_d[15:8]  = in_byte;
            2'd2: word_d[23:16] = in_byte;
            default: begin
              // Fourth byte completes the word: register the write so the
              // strobe, address and data all appear together next cycle.
              im_we_d    = 1'b1;
              im_addr_d  = BASE_ADDR + word_off;
              im_wdata_d = {in_byte, word_q};
              word_idx_d = word_idx_q + {{(WIDX_W-1){1'b0}}, 1'b1};
              if (last_word) begin
                state_d = ST_CSUM;
              end
            end
          endcase
        end
      end

      ST_CSUM: begin
        if (accept) begin
          if (in_byte == csum_q) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            core_hold_d = 1'b0;
          end else begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= 16'h0000;
      word_q      <= 24'h0;
      byte_idx_q  <= 2'd0;
      word_idx_q  <= '0;
      csum_q      <= 8'h00;
      im_we_q     <= 1'b0;
      im_addr_q   <= BASE_ADDR;
      im_wdata_q  <= 32'h0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      core_hold_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_q      <= word_d;
      byte_idx_q  <= byte_idx_d;
      word_idx_q  <= word_idx_d;
      csum_q      <= csum_d;
      im_we_q     <= im_we_d;
      im_addr_q   <= im_addr_d;
      im_wdata_q  <= im_wdata_d;
      done_q      <= done_d;
      error_q     <= error_d;
      core_hold_q <= core_hold_d;
    end
  end

  assign im_we     = im_we_q;
  assign im_addr   = im_addr_q;
  assign im_wdata  = im_wdata_q;
  assign done      = done_q;
  assign error     = error_q;
  assign core_hold = core_hold_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_im_loader.sv
// -----------------------------------------------------------------------------
// tb_im_loader
//
// Table of frames (length, words, checksum byte, gap mode, expected outcome)
// applied in a loop, followed by hand-written sequences for length overflow,
// the DEPTH boundary length and reset in the middle of a load. Expected writes
// are queued before each frame and popped by a monitor on every im_we.
// -----------------------------------------------------------------------------
module tb_im_loader;

  localparam int unsigned DEPTH     = 256;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
  localparam logic [2:0]  ST_IDLE   = 3'd0;
  localparam logic [2:0]  ST_DATA   = 3'd3;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        core_hold;
  logic        done;
  logic        error;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  im_loader #(
    .DEPTH(DEPTH),
    .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_valid(in_valid),
    .in_byte(in_byte),
    .in_ready(in_ready),
    .im_we(im_we),
    .im_addr(im_addr),
    .im_wdata(im_wdata),
    .core_hold(core_hold),
    .done(done),
    .error(error),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];  // {addr, data}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: actual addr=%0h data=%0h required=no write",
                 im_addr, im_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("write", {im_addr, im_wdata}, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- frame table ----------------
  typedef struct {
    string            name;
    logic [15:0]      len;
    logic [2:0][31:0] w;
    logic [7:0]       csum;
    bit               gaps;
    bit               exp_done;
    bit               exp_err;
  } frame_t;

  frame_t tbl[7];

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a falling edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 3);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
    end
    in_valid = 1'b1;
    in_byte  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL in_ready_timeout: actual=0 required=1 (byte %0h)", b);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);  // the posedge in between consumed the byte
      in_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),  64'd0);
    check({tag, "_im_we"},     64'(im_we),     64'd0);
    check({tag, "_im_addr"},   64'(im_addr),   64'(BASE_ADDR));
    check({tag, "_im_wdata"},  64'(im_wdata),  64'd0);
    check({tag, "_core_hold"}, 64'(core_hold), 64'd1);
    check({tag, "_done"},      64'(done),      64'd0);
    check({tag, "_error"},     64'(error),     64'd0);
    check({tag, "_state"},     64'(dbg_state), 64'(ST_IDLE));
  endtask

  task automatic run_frame(input int idx);
    frame_t f;
    logic [31:0] wv;
    f = tbl[idx];
    for (int i = 0; i < int'(f.len); i++) begin
      exp_q.push_back({BASE_ADDR + 32'(i * 4), f.w[i]});
    end
    pulse_start();
    check({f.name, "_hold_at_start"}, 64'(core_hold), 64'd1);
    check({f.name, "_done_cleared"},  64'(done),      64'd0);
    check({f.name, "_err_cleared"},   64'(error),     64'd0);
    send_byte(f.len[7:0], f.gaps);
    send_byte(f.len[15:8], f.gaps);
    for (int i = 0; i < int'(f.len); i++) begin
      wv = f.w[i];
      for (int b = 0; b < 4; b++) begin
        send_byte(wv[8*b +: 8], f.gaps);
        if (f.gaps && i == 0 && b == 2) begin
          // start must be ignored in the middle of DATA
          pulse_start();
          check({f.name, "_start_ignored"}, 64'(dbg_state), 64'(ST_DATA));
        end
      end
    end
    send_byte(f.csum, f.gaps);
    check({f.name, "_done"},      64'(done),      64'(f.exp_done));
    check({f.name, "_error"},     64'(error),     64'(f.exp_err));
    check({f.name, "_core_hold"}, 64'(core_hold), 64'(!f.exp_done));
    check({f.name, "_in_ready"},  64'(in_ready),  64'd0);
    @(negedge clk);
    check({f.name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    // XOR of 13 05 A0 00 93 05 B0 00 is 0x90.
    tbl[0] = '{"two_word",      16'd2, {32'h0, 32'h00B00593, 32'h00A00513}, 8'h90, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{"bad_csum",      16'd2, {32'h0, 32'h00B00593, 32'h00A00513}, 8'h34, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{"zero_len",      16'd0, {32'h0, 32'h0, 32'h0},               8'h00, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{"two_word_gaps", 16'd2, {32'h0, 32'h00B00593, 32'h00A00513}, 8'h90, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{"one_word",      16'd1, {32'h0, 32'h0, 32'hDEADBEEF},        8'h22, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{"zero_len_bad",  16'd0, {32'h0, 32'h0, 32'h0},               8'h01, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{"three_word",    16'd3, {32'hFF000000, 32'h0, 32'h01020304}, 8'hFB, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_byte = 8'h00;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_frame(i);
    end

    // Length overflow: 257 > DEPTH
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    check("ovf_error",     64'(error),     64'd1);
    check("ovf_done",      64'(done),      64'd0);
    check("ovf_core_hold", 64'(core_hold), 64'd1);
    check("ovf_in_ready",  64'(in_ready),  64'd0);
    repeat (4) @(negedge clk);
    check("ovf_in_ready_hold", 64'(in_ready), 64'd0);

    // Boundary: len == DEPTH is accepted into DATA, then aborted by reset
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    check("len_depth_error", 64'(error),     64'd0);
    check("len_depth_state", 64'(dbg_state), 64'(ST_DATA));
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_boundary");
    rst = 1'b0;

    // Reset after 6 data bytes: only word 0 was completed
    exp_q.push_back({BASE_ADDR, 32'h00A00513});
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'hA0, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h93, 1'b0);
    send_byte(8'h05, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_midload");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_writes_left", 64'(exp_q.size()), 64'd0);

    // Fresh load after the abort starts again at BASE_ADDR
    run_frame(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
